// File: rtl/sched_pkg.sv
// Shared definitions for the round-robin engine scheduler: FSM encoding,
// default watchdog limit and an index-width helper.
package sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANT   = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_RELEASE = 3'd4
    } sched_state_t;

    localparam int unsigned TMO_LIMIT_DEF = 992;

    // Width needed to index n items; never less than one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r++;
        return (r == 0) ? 32'd1 : r;
    endfunction

endpackage

// File: rtl/engine_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping from the top index back to zero.
module rr_pick
    import sched_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned OW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [OW-1:0]   ptr,
    output logic            valid,
    output logic [OW-1:0]   idx
);

    // Scan from the farthest offset down so the nearest request overwrites last.
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int unsigned i = NREQ; i > 0; i--) begin
            if (req[(32'(ptr) + i - 1) % NREQ]) begin
                idx = OW'((32'(ptr) + i - 1) % NREQ);
            end
        end
    end

endmodule

// File: rtl/engine_rr_scheduler.sv
// Round-robin scheduler sharing one two-operand engine between NREQ requesters,
// with operand capture, one-cycle start, done/watchdog completion and release.
module engine_rr_scheduler
    import sched_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DW        = 8,
    parameter int unsigned TW        = 10,
    parameter int unsigned TMO_LIMIT = TMO_LIMIT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_opa,
    input  logic [NREQ*DW-1:0] req_opb,
    output logic [NREQ-1:0]    gnt,
    output logic               eng_start,
    output logic [DW-1:0]      eng_opa,
    output logic [DW-1:0]      eng_opb,
    input  logic               eng_done,
    output logic [NREQ-1:0]    cmp_done,
    output logic               tmo,
    output logic [2:0]         tmo_id,
    output logic               busy
);

    localparam int unsigned OW = clog2(NREQ);

    sched_state_t    state, state_nxt;
    logic [OW-1:0]   owner, owner_nxt;
    logic [OW-1:0]   rr_ptr, ptr_nxt;
    logic [TW-1:0]   wdog, wdog_nxt;
    logic            pend, pend_nxt;
    logic            pick_valid;
    logic [OW-1:0]   pick_idx;
    logic [NREQ-1:0] owner_oh;
    logic [NREQ-1:0] gnt_nxt, cmp_nxt;
    logic            start_nxt, tmo_nxt;
    logic [2:0]      tmoid_nxt;
    logic [DW-1:0]   opa_nxt, opb_nxt;

    rr_pick #(.NREQ(NREQ), .OW(OW)) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign owner_oh = NREQ'(1) << owner;
    assign busy     = (state != ST_IDLE);

    // Pulses default low every clock, so a disabled cycle can never stretch one.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = rr_ptr;
        wdog_nxt  = wdog;
        pend_nxt  = pend;
        gnt_nxt   = '0;
        start_nxt = 1'b0;
        cmp_nxt   = '0;
        tmo_nxt   = 1'b0;
        tmoid_nxt = tmo_id;
        opa_nxt   = eng_opa;
        opb_nxt   = eng_opb;
        if (!en) begin
            if (state == ST_WAIT && eng_done) pend_nxt = 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        owner_nxt = pick_idx;
                        state_nxt = ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (req[owner]) begin
                        gnt_nxt   = owner_oh;
                        opa_nxt   = req_opa[int'(owner)*DW +: DW];
                        opb_nxt   = req_opb[int'(owner)*DW +: DW];
                        state_nxt = ST_ISSUE;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    start_nxt = 1'b1;
                    wdog_nxt  = '0;
                    state_nxt = ST_WAIT;
                end
                ST_WAIT: begin
                    pend_nxt = 1'b0;
                    if (wdog != '1) wdog_nxt = wdog + 1'b1;
                    if (eng_done || pend) begin
                        cmp_nxt   = owner_oh;
                        state_nxt = ST_RELEASE;
                    end else if (wdog == TW'(TMO_LIMIT - 1)) begin
                        tmo_nxt   = 1'b1;
                        tmoid_nxt = 3'(owner);
                        state_nxt = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    ptr_nxt   = (owner == OW'(NREQ - 1)) ? '0 : owner + 1'b1;
                    opa_nxt   = '0;
                    opb_nxt   = '0;
                    state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            wdog      <= '0;
            pend      <= 1'b0;
            gnt       <= '0;
            eng_start <= 1'b0;
            eng_opa   <= '0;
            eng_opb   <= '0;
            cmp_done  <= '0;
            tmo       <= 1'b0;
            tmo_id    <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            rr_ptr    <= ptr_nxt;
            wdog      <= wdog_nxt;
            pend      <= pend_nxt;
            gnt       <= gnt_nxt;
            eng_start <= start_nxt;
            eng_opa   <= opa_nxt;
            eng_opb   <= opb_nxt;
            cmp_done  <= cmp_nxt;
            tmo       <= tmo_nxt;
            tmo_id    <= tmoid_nxt;
        end
    end

endmodule

// File: tb/tb_engine_rr_scheduler.sv
// Self-checking bench for engine_rr_scheduler: directed vector table, hand
// sequences for abort/reset corners, and random jobs against a job-level model.
module tb_engine_rr_scheduler;

    localparam int TMO_LIMIT = 992;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  req;
    logic [31:0] req_opa;
    logic [31:0] req_opb;
    logic [3:0]  gnt;
    logic        eng_start;
    logic [7:0]  eng_opa;
    logic [7:0]  eng_opb;
    logic        eng_done;
    logic [3:0]  cmp_done;
    logic        tmo;
    logic [2:0]  tmo_id;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int model_ptr = 0;
    int last_tmo  = 0;

    engine_rr_scheduler #(.NREQ(4), .DW(8), .TW(10), .TMO_LIMIT(TMO_LIMIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .req_opa   (req_opa),
        .req_opb   (req_opb),
        .gnt       (gnt),
        .eng_start (eng_start),
        .eng_opa   (eng_opa),
        .eng_opb   (eng_opb),
        .eng_done  (eng_done),
        .cmp_done  (cmp_done),
        .tmo       (tmo),
        .tmo_id    (tmo_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    typedef struct {
        logic [3:0] rq;
        logic [7:0] opa;
        logic [7:0] opb;
        int         done_at;
        int         gap_at;
        int         gap_len;
        int         exp_win;
    } vec_t;

    vec_t vecs[13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_pick(input logic [3:0] rq, input int p);
        for (int i = 0; i < 4; i++) begin
            if (rq[(p + i) % 4]) return (p + i) % 4;
        end
        return -1;
    endfunction

    // One job from IDLE to back in IDLE. The job ends on the first enabled WAIT
    // edge after done has been seen, or after TMO_LIMIT enabled WAIT edges.
    task automatic run_job(input logic [3:0] rq, input logic [31:0] av, input logic [31:0] bv,
                           input int win, input int done_at, input int gap_at, input int gap_len);
        logic [3:0] oh;
        int  en_edges;
        bit  seen, ended, was_tmo, bad, exp_end, exp_tmo;
        oh = 4'(1 << win);
        req = rq; req_opa = av; req_opb = bv; en = 1'b1; eng_done = 1'b0;
        tick();
        chk("gnt_early", 32'(gnt), 0);
        chk("busy_on", 32'(busy), 1);
        tick();
        chk("gnt", 32'(gnt), 32'(oh));
        chk("start_early", 32'(eng_start), 0);
        req = rq & ~oh;
        tick();
        chk("start", 32'(eng_start), 1);
        chk("gnt_pulse", 32'(gnt), 0);
        chk("eng_opa", 32'(eng_opa), 32'(av[win*8 +: 8]));
        chk("eng_opb", 32'(eng_opb), 32'(bv[win*8 +: 8]));
        en_edges = 0; seen = 0; ended = 0; was_tmo = 0; bad = 0;
        for (int k = 0; k < 3000 && !ended; k++) begin
            en = !(gap_len > 0 && k >= gap_at && k < gap_at + gap_len);
            eng_done = (k == done_at);
            exp_end = 0; exp_tmo = 0;
            if (en) begin
                en_edges++;
                if (seen || eng_done) exp_end = 1;
                else if (en_edges == TMO_LIMIT) begin exp_end = 1; exp_tmo = 1; end
            end else if (eng_done) begin
                seen = 1;
            end
            tick();
            if (exp_end) begin
                ended = 1;
                was_tmo = exp_tmo;
                chk("cmp_done", 32'(cmp_done), exp_tmo ? 0 : 32'(oh));
                chk("tmo", 32'(tmo), 32'(exp_tmo));
                if (exp_tmo) begin
                    chk("tmo_id", 32'(tmo_id), 32'(win));
                    last_tmo = win;
                end
            end else if (cmp_done != 0 || tmo || eng_start || gnt != 0 || !busy ||
                         eng_opa != av[win*8 +: 8]) begin
                bad = 1;
            end
        end
        chk("job_end", 32'(ended), 1);
        chk("wait_quiet", 32'(bad), 0);
        en = 1'b1; eng_done = 1'b0;
        tick();
        chk("busy_off", 32'(busy), 0);
        chk("opa_clr", 32'({eng_opb, eng_opa}), 0);
        chk("no_pulse", 32'({cmp_done, tmo}), 0);
        chk("tmo_id_hold", 32'(tmo_id), 32'(last_tmo));
        model_ptr = (win + 1) % 4;
    endtask

    initial begin
        logic [31:0] av, bv;
        logic [3:0]  rq;
        int          win, da, ga, gl;

        vecs[0]  = '{4'b1111, 8'hA0, 8'hB0, 0, 0, 0, 0};
        vecs[1]  = '{4'b1111, 8'hA1, 8'hB1, 0, 0, 0, 1};
        vecs[2]  = '{4'b1111, 8'hA2, 8'hB2, 0, 0, 0, 2};
        vecs[3]  = '{4'b1111, 8'hA3, 8'hB3, 0, 0, 0, 3};
        vecs[4]  = '{4'b1111, 8'hA4, 8'hB4, 0, 0, 0, 0};
        vecs[5]  = '{4'b0001, 8'h5A, 8'hC3, 5, 0, 0, 0};
        vecs[6]  = '{4'b0110, 8'h13, 8'h24, 2, 0, 0, 1};
        vecs[7]  = '{4'b1001, 8'h35, 8'h46, 1, 0, 0, 3};
        vecs[8]  = '{4'b1010, 8'h57, 8'h68, 3, 0, 0, 1};
        vecs[9]  = '{4'b0100, 8'h79, 8'h8A, -1, 0, 0, 2};
        vecs[10] = '{4'b0011, 8'h9B, 8'hAC, TMO_LIMIT - 1, 0, 0, 0};
        vecs[11] = '{4'b0010, 8'hBD, 8'hCE, 4, 2, 7, 1};
        vecs[12] = '{4'b1000, 8'hDF, 8'hE0, -1, 10, 7, 3};

        rst = 1'b1; en = 1'b1; req = '0; req_opa = '0; req_opb = '0; eng_done = 1'b0;
        tick(); tick();
        chk("reset_outs", 32'({gnt, eng_start, eng_opa, eng_opb, cmp_done, tmo, tmo_id, busy}), 0);
        rst = 1'b0;
        tick();

        for (int r = 0; r < 13; r++) begin
            for (int i = 0; i < 4; i++) begin
                av[i*8 +: 8] = vecs[r].opa + 8'(i * 17);
                bv[i*8 +: 8] = vecs[r].opb + 8'(i * 17);
            end
            run_job(vecs[r].rq, av, bv, vecs[r].exp_win, vecs[r].done_at,
                    vecs[r].gap_at, vecs[r].gap_len);
        end

        // Winner withdraws before GRANT: no grant, pointer unchanged; done in IDLE ignored.
        req = 4'b0010; eng_done = 1'b1;
        tick();
        chk("drop_busy", 32'(busy), 1);
        req = '0;
        tick();
        chk("drop_gnt", 32'(gnt), 0);
        chk("drop_idle", 32'(busy), 0);
        chk("drop_cmp", 32'(cmp_done), 0);
        eng_done = 1'b0;
        run_job(4'b1111, 32'h44332211, 32'h88776655, model_pick(4'b1111, model_ptr), 1, 0, 0);

        // Reset while waiting on the engine abandons the job silently.
        req = 4'b0010; req_opa = 32'hFFEEDDCC; req_opb = 32'h11223344;
        tick(); tick();
        chk("rstseq_gnt", 32'(gnt), 32'h2);
        req = '0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        chk("rst_wait_outs", 32'({gnt, eng_start, eng_opa, eng_opb, cmp_done, tmo, tmo_id, busy}), 0);
        rst = 1'b0; eng_done = 1'b1;
        tick(); tick();
        chk("rst_no_cmp", 32'({cmp_done, tmo, busy}), 0);
        eng_done = 1'b0;
        model_ptr = 0; last_tmo = 0;
        run_job(4'b1111, 32'h0F0E0D0C, 32'h0B0A0908, 0, 2, 0, 0);
        model_ptr = 0;
        run_job(4'b1000, 32'h12345678, 32'h9ABCDEF0, 3, 0, 0, 0);

        for (int n = 0; n < 30; n++) begin
            rq = 4'($urandom_range(1, 15));
            av = $urandom;
            bv = $urandom;
            win = model_pick(rq, model_ptr);
            da = $urandom_range(0, 5);
            if ($urandom_range(0, 3) == 0) begin
                ga = $urandom_range(0, 4);
                gl = $urandom_range(1, 5);
            end else begin
                ga = 0;
                gl = 0;
            end
            run_job(rq, av, bv, win, da, ga, gl);
        end

        req = '0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
